// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction fetch stage.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  // BUBBLE: IF/ID holds a NOP; FILL: IF/ID holds a real instruction.
  typedef enum logic {
    BUBBLE = 1'b0,
    FILL   = 1'b1
  } fetch_state_t;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [WORD_W-1:0] alignWord(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage, the hazard/branch logic, instruction memory and decode.
interface fetch_if;
  import mips_pkg::*;

  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_target;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic [WORD_W-1:0] instruction;
  logic [WORD_W-1:0] pc_plus4;
  logic              valid;
  logic [WORD_W-1:0] fetch_count;

  // Environment side: hazard unit, branch unit, instruction memory and decode.
  modport master (
    output stall, redirect, redirect_target, imem_rdata,
    input  imem_addr, instruction, pc_plus4, valid, fetch_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, redirect, redirect_target, imem_rdata,
    output imem_addr, instruction, pc_plus4, valid, fetch_count
  );

endinterface

// File: rtl/program_counter.sv
// Program counter: priority next-PC mux (redirect > stall > advance) with
// word alignment of redirect targets.
module program_counter
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [WORD_W-1:0] i_redirectTarget,
  output logic [WORD_W-1:0] o_pc
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_nextPc;

  // Choose the next PC; a redirect wins even when a stall is requested.
  always_comb begin
    w_nextPc = r_pc;
    if (i_redirect) begin
      w_nextPc = alignWord(i_redirectTarget);
    end else if (!i_stall) begin
      w_nextPc = r_pc + 32'd4;
    end
  end

  // PC register; the add wraps naturally from FFFF_FFFC to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, IF/ID pipeline register, bubble/fill FSM and
// a count of instructions delivered to decode.
module fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.slave bus
);

  logic [WORD_W-1:0] w_pc;
  logic [WORD_W-1:0] w_pcPlus4;
  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_instruction;
  logic [WORD_W-1:0] r_pcPlus4;
  logic [WORD_W-1:0] r_fetchCount;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_programCounter (
    .clk              (clk),
    .reset            (reset),
    .i_stall          (bus.stall),
    .i_redirect       (bus.redirect),
    .i_redirectTarget (bus.redirect_target),
    .o_pc             (w_pc)
  );

  assign w_pcPlus4 = w_pc + 32'd4;

  // IF/ID register, FSM and fetch counter: redirect flushes, stall holds, otherwise latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BUBBLE;
      r_instruction <= NOP_WORD;
      r_pcPlus4     <= '0;
      r_fetchCount  <= '0;
    end else if (bus.redirect) begin
      r_state       <= BUBBLE;
      r_instruction <= NOP_WORD;
    end else if (!bus.stall) begin
      r_state       <= FILL;
      r_instruction <= bus.imem_rdata;
      r_pcPlus4     <= w_pcPlus4;
      r_fetchCount  <= r_fetchCount + 32'd1;
    end
  end

  assign bus.imem_addr   = w_pc;
  assign bus.instruction = r_instruction;
  assign bus.pc_plus4    = r_pcPlus4;
  assign bus.valid       = (r_state == FILL);
  assign bus.fetch_count = r_fetchCount;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage with a scoreboard of expected IF/ID contents.
module tb_fetch;
  import mips_pkg::*;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] plus4;
  } fetchExp_t;

  logic      clk = 1'b0;
  logic      reset;
  fetch_if   busIf ();
  fetchExp_t sbQueue[$];
  int        total = 0;
  int        bad = 0;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPlus4;
  logic [31:0] mCount;
  logic        mValid;

  fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (TB_NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0007;
      default:       return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Instruction memory answers combinationally from the current fetch address.
  assign busIf.imem_rdata = memWord(busIf.imem_addr);

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveEdge(input logic s, input logic r, input logic [31:0] t);
    busIf.stall           = s;
    busIf.redirect        = r;
    busIf.redirect_target = t;
    if (r) begin
      mPc    = {t[31:2], 2'b00};
      mInstr = TB_NOP;
      mValid = 1'b0;
    end else if (!s) begin
      sbQueue.push_back('{memWord(mPc), mPc + 32'd4});
      mPc    = mPc + 32'd4;
      mCount = mCount + 32'd1;
      mValid = 1'b1;
    end
    @(posedge clk);
    #1;
    busIf.stall    = 1'b0;
    busIf.redirect = 1'b0;
  endtask

  task automatic test_reset();
    busIf.stall = 1'b0;
    busIf.redirect = 1'b0;
    busIf.redirect_target = '0;
    reset = 1'b1;
    mPc = 32'h0; mInstr = TB_NOP; mPlus4 = 32'h0; mCount = 32'h0; mValid = 1'b0;
    #12;
    total++; if (busIf.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=%h", busIf.imem_addr, 32'h0); end
    total++; if (busIf.instruction !== TB_NOP) begin bad++; $display("[TB] FAIL reset_instr got=%h want=%h", busIf.instruction, TB_NOP); end
    total++; if (busIf.pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_plus4 got=%h want=%h", busIf.pc_plus4, 32'h0); end
    total++; if (busIf.valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", busIf.valid); end
    total++; if (busIf.fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", busIf.fetch_count); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busIf.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL release_addr got=%h want=%h", busIf.imem_addr, 32'h0); end
  endtask

  task automatic test_free_run();
    fetchExp_t e;
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL run1_addr got=%h want=%h", busIf.imem_addr, 32'h4); end
    total++; if (busIf.instruction !== 32'h2001_0005) begin bad++; $display("[TB] FAIL run1_instr got=%h want=%h", busIf.instruction, 32'h2001_0005); end
    total++; if (busIf.pc_plus4 !== e.plus4) begin bad++; $display("[TB] FAIL run1_plus4 got=%h want=%h", busIf.pc_plus4, e.plus4); end
    total++; if (busIf.valid !== 1'b1) begin bad++; $display("[TB] FAIL run1_valid got=%b want=1", busIf.valid); end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL run2_addr got=%h want=%h", busIf.imem_addr, 32'h8); end
    total++; if (busIf.instruction !== 32'h2002_0007) begin bad++; $display("[TB] FAIL run2_instr got=%h want=%h", busIf.instruction, 32'h2002_0007); end
    total++; if (busIf.pc_plus4 !== 32'h8) begin bad++; $display("[TB] FAIL run2_plus4 got=%h want=%h", busIf.pc_plus4, 32'h8); end
    total++; if (busIf.fetch_count !== 32'd2) begin bad++; $display("[TB] FAIL run2_count got=%0d want=2", busIf.fetch_count); end
  endtask

  task automatic test_stall();
    fetchExp_t e;
    for (int i = 0; i < 2; i++) begin
      driveEdge(1'b1, 1'b0, 32'h0);
      total++; if (busIf.imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_addr got=%h want=%h", busIf.imem_addr, 32'h8); end
      total++; if (busIf.instruction !== 32'h2002_0007) begin bad++; $display("[TB] FAIL stall_instr got=%h want=%h", busIf.instruction, 32'h2002_0007); end
      total++; if (busIf.pc_plus4 !== 32'h8) begin bad++; $display("[TB] FAIL stall_plus4 got=%h want=%h", busIf.pc_plus4, 32'h8); end
      total++; if (busIf.fetch_count !== 32'd2) begin bad++; $display("[TB] FAIL stall_count got=%0d want=2", busIf.fetch_count); end
    end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.imem_addr !== 32'hC) begin bad++; $display("[TB] FAIL resume_addr got=%h want=%h", busIf.imem_addr, 32'hC); end
    total++; if (busIf.instruction !== e.instr) begin bad++; $display("[TB] FAIL resume_instr got=%h want=%h", busIf.instruction, e.instr); end
    total++; if (busIf.fetch_count !== 32'd3) begin bad++; $display("[TB] FAIL resume_count got=%0d want=3", busIf.fetch_count); end
  endtask

  task automatic test_redirect();
    fetchExp_t e;
    driveEdge(1'b0, 1'b1, 32'h0000_0043);
    total++; if (busIf.imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL redir_addr got=%h want=%h", busIf.imem_addr, 32'h40); end
    total++; if (busIf.valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_valid got=%b want=0", busIf.valid); end
    total++; if (busIf.instruction !== TB_NOP) begin bad++; $display("[TB] FAIL redir_instr got=%h want=%h", busIf.instruction, TB_NOP); end
    total++; if (busIf.pc_plus4 !== 32'hC) begin bad++; $display("[TB] FAIL redir_plus4 got=%h want=%h", busIf.pc_plus4, 32'hC); end
    total++; if (busIf.fetch_count !== 32'd3) begin bad++; $display("[TB] FAIL redir_count got=%0d want=3", busIf.fetch_count); end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.instruction !== memWord(32'h40)) begin bad++; $display("[TB] FAIL target_instr got=%h want=%h", busIf.instruction, memWord(32'h40)); end
    total++; if (busIf.pc_plus4 !== 32'h44) begin bad++; $display("[TB] FAIL target_plus4 got=%h want=%h", busIf.pc_plus4, 32'h44); end
    total++; if (busIf.valid !== 1'b1) begin bad++; $display("[TB] FAIL target_valid got=%b want=1", busIf.valid); end
  endtask

  task automatic test_redirect_stall();
    fetchExp_t e;
    driveEdge(1'b1, 1'b1, 32'h0000_0100);
    total++; if (busIf.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL rs_addr got=%h want=%h", busIf.imem_addr, 32'h100); end
    total++; if (busIf.valid !== 1'b0) begin bad++; $display("[TB] FAIL rs_valid got=%b want=0", busIf.valid); end
    total++; if (busIf.fetch_count !== 32'd4) begin bad++; $display("[TB] FAIL rs_count got=%0d want=4", busIf.fetch_count); end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.instruction !== e.instr) begin bad++; $display("[TB] FAIL rs_next_instr got=%h want=%h", busIf.instruction, e.instr); end
    total++; if (busIf.pc_plus4 !== 32'h104) begin bad++; $display("[TB] FAIL rs_next_plus4 got=%h want=%h", busIf.pc_plus4, 32'h104); end
  endtask

  task automatic test_wrap();
    fetchExp_t e;
    driveEdge(1'b0, 1'b1, 32'hFFFF_FFFF);
    total++; if (busIf.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pre_addr got=%h want=%h", busIf.imem_addr, 32'hFFFF_FFFC); end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_addr got=%h want=%h", busIf.imem_addr, 32'h0); end
    total++; if (busIf.pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_plus4 got=%h want=%h", busIf.pc_plus4, 32'h0); end
    total++; if (busIf.instruction !== memWord(32'hFFFF_FFFC)) begin bad++; $display("[TB] FAIL wrap_instr got=%h want=%h", busIf.instruction, memWord(32'hFFFF_FFFC)); end
  endtask

  task automatic test_back_to_back();
    fetchExp_t e;
    logic s;
    logic r;
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 4) == 0);
      t = $urandom;
      driveEdge(s, r, t);
      if (!r && !s) begin
        if (sbQueue.size() == 0) begin
          total++; bad++; $display("[TB] FAIL b2b_queue got=empty want=entry");
        end else begin
          e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
        end
      end
      total++; if (busIf.imem_addr !== mPc) begin bad++; $display("[TB] FAIL b2b_addr[%0d] got=%h want=%h", i, busIf.imem_addr, mPc); end
      total++; if (busIf.instruction !== mInstr) begin bad++; $display("[TB] FAIL b2b_instr[%0d] got=%h want=%h", i, busIf.instruction, mInstr); end
      total++; if (busIf.pc_plus4 !== mPlus4) begin bad++; $display("[TB] FAIL b2b_plus4[%0d] got=%h want=%h", i, busIf.pc_plus4, mPlus4); end
      total++; if (busIf.valid !== mValid) begin bad++; $display("[TB] FAIL b2b_valid[%0d] got=%b want=%b", i, busIf.valid, mValid); end
      total++; if (busIf.fetch_count !== mCount) begin bad++; $display("[TB] FAIL b2b_count[%0d] got=%0d want=%0d", i, busIf.fetch_count, mCount); end
    end
  endtask

  task automatic test_async_reset();
    fetchExp_t e;
    driveEdge(1'b0, 1'b1, 32'h0000_0020);
    total++; if (busIf.imem_addr !== 32'h20) begin bad++; $display("[TB] FAIL ar_pre_addr got=%h want=%h", busIf.imem_addr, 32'h20); end
    #3;
    busIf.stall = 1'b1;
    busIf.redirect = 1'b1;
    busIf.redirect_target = 32'h0000_0080;
    #1;
    reset = 1'b1;
    #1;
    total++; if (busIf.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL ar_addr got=%h want=%h", busIf.imem_addr, 32'h0); end
    total++; if (busIf.instruction !== TB_NOP) begin bad++; $display("[TB] FAIL ar_instr got=%h want=%h", busIf.instruction, TB_NOP); end
    total++; if (busIf.pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL ar_plus4 got=%h want=%h", busIf.pc_plus4, 32'h0); end
    total++; if (busIf.valid !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid got=%b want=0", busIf.valid); end
    total++; if (busIf.fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL ar_count got=%0d want=0", busIf.fetch_count); end
    @(posedge clk);
    #2;
    busIf.stall = 1'b0;
    busIf.redirect = 1'b0;
    reset = 1'b0;
    mPc = 32'h0; mInstr = TB_NOP; mPlus4 = 32'h0; mCount = 32'h0; mValid = 1'b0;
    sbQueue.delete();
    #1;
    total++; if (busIf.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL ar_release_addr got=%h want=%h", busIf.imem_addr, 32'h0); end
    driveEdge(1'b0, 1'b0, 32'h0);
    e = sbQueue.pop_front(); mInstr = e.instr; mPlus4 = e.plus4;
    total++; if (busIf.instruction !== 32'h2001_0005) begin bad++; $display("[TB] FAIL ar_first_instr got=%h want=%h", busIf.instruction, 32'h2001_0005); end
    total++; if (busIf.pc_plus4 !== 32'h4) begin bad++; $display("[TB] FAIL ar_first_plus4 got=%h want=%h", busIf.pc_plus4, 32'h4); end
    total++; if (busIf.fetch_count !== 32'd1) begin bad++; $display("[TB] FAIL ar_first_count got=%0d want=1", busIf.fetch_count); end
    total++; if (busIf.imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL ar_first_addr got=%h want=%h", busIf.imem_addr, 32'h4); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
